layer_sched: RTL

//  Layer-level scheduler for the accelerator core. Queues layer commands (CONV/POOL/NL) and launches one engine controller at a time.

---
 rtl/sched_pkg.sv | 48 ++++
 rtl/sched_cmd_fifo.sv | 71 +++++++
 rtl/layer_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared types for the layer scheduler.
//   op_t    : layer command opcode (CONV, POOL, NL, reserved)
//   owner_t : which engine currently owns the PE array and BUF1/BUF2 m1 paths
//   state_t : scheduler FSM state
//   cmd_t   : one queued layer command {op, swap, last}
// owner_of() maps an opcode to its owner code. The reserved op maps to NONE,
// so that op can never grant ownership.
package sched_pkg;

    typedef enum logic [1:0] {
        OP_CONV = 2'd0,
        OP_POOL = 2'd1,
        OP_NL   = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CONV = 2'd1,
        OWN_POOL = 2'd2,
        OWN_NL   = 2'd3
    } owner_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SWAP   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    typedef struct packed {
        op_t  op;
        logic swap;
        logic last;
    } cmd_t;

    function automatic owner_t owner_of(input op_t op);
        case (op)
            OP_CONV: return OWN_CONV;
            OP_POOL: return OWN_POOL;
            OP_NL:   return OWN_NL;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous show-ahead FIFO of layer commands.
// Ports:
//   clk_i    core clock
//   rst_ni   synchronous active-low reset (empties the FIFO)
//   flush_i  synchronous flush (empties the FIFO; wins over push/pop)
//   push_i   write data_i when not full
//   data_i   command to enqueue
//   pop_i    drop the head entry when not empty
//   data_o   head entry (valid when empty_o = 0)
//   full_o   DEPTH entries held
//   empty_o  no entries held
// The pointers carry one extra wrap bit so full and empty are told apart
// without an occupancy counter. DEPTH must be a power of two, >= 2.
module sched_cmd_fifo
    import sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  cmd_t data_i,
    input  logic pop_i,
    output cmd_t data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    cmd_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage holds data only; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/layer_sched.sv
// Layer-level scheduler: queues CONV/POOL/NL layer commands and launches one
// engine controller at a time, granting it the shared PE array and the
// BUF1/BUF2 m1 control paths through owner_sel. Tracks the buffer ping-pong
// direction across layers.
// Ports:
//   clk, rst (sync, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_swap/cmd_last   command enqueue
//   go                                             start executing the queue
//   conv_start/pool_start/nl_start                 1-cycle engine starts
//   conv_done/pool_done/nl_done                    1-cycle engine completions
//   owner_sel     0 NONE, 1 CONV, 2 POOL, 3 NL
//   aybz_azby     0 = read BUF1/write BUF2, 1 = reverse
//   busy, layer_cnt, done, err
// Optional feature: define LAYER_SCHED_WDOG_EN for a WAIT-state watchdog
// (WDOG_W >= 2) that aborts a hung layer back to IDLE with err set and the
// command FIFO flushed. Without it WAIT waits indefinitely.
// Every output is a flop loaded from the next-state values, so each output
// reflects the state that the FSM is in during that same cycle.
module layer_sched
    import sched_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WDOG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_swap,
    input  logic             cmd_last,
    input  logic             go,
    output logic             conv_start,
    output logic             pool_start,
    output logic             nl_start,
    input  logic             conv_done,
    input  logic             pool_done,
    input  logic             nl_done,
    output logic [1:0]       owner_sel,
    output logic             aybz_azby,
    output logic             busy,
    output logic [CNT_W-1:0] layer_cnt,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    cmd_t             cur_q, cur_d;
    logic             go_q;
    logic             aybz_q, aybz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    owner_t           owner_q, owner_d;
    logic             conv_start_q, pool_start_q, nl_start_q;
    logic             busy_q, done_q;

    cmd_t             fifo_in, fifo_out;
    logic             fifo_full, fifo_empty;
    logic             fifo_pop, fifo_flush;
    logic             match_done, other_done;
    logic             wdog_hit;

    always_comb begin
        fifo_in      = '0;
        fifo_in.op   = op_t'(cmd_op);
        fifo_in.swap = cmd_swap;
        fifo_in.last = cmd_last;
    end

    sched_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .flush_i (fifo_flush),
        .push_i  (cmd_valid),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = !fifo_full;

    // Split the done inputs into the one belonging to the running layer and
    // any stray completion from an engine that should be idle.
    always_comb begin
        match_done = 1'b0;
        other_done = 1'b0;
        case (cur_q.op)
            OP_CONV: begin
                match_done = conv_done;
                other_done = pool_done | nl_done;
            end
            OP_POOL: begin
                match_done = pool_done;
                other_done = conv_done | nl_done;
            end
            OP_NL: begin
                match_done = nl_done;
                other_done = conv_done | pool_done;
            end
            default: begin
                match_done = 1'b0;
                other_done = conv_done | pool_done | nl_done;
            end
        endcase
    end

`ifdef LAYER_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_q;

    // Count 0 is the WAIT entry cycle; the abort happens on the edge where
    // the count would reach all-ones, i.e. after 2^WDOG_W-1 WAIT cycles.
    assign wdog_hit = (state_q == ST_WAIT) &&
                      (wdog_q == {{(WDOG_W-1){1'b1}}, 1'b0});

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
            wdog_q <= wdog_q + 1'b1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    assign wdog_hit = 1'b0;

    // WDOG_W sizes nothing in this build; it stays in the parameter list so
    // both builds share one interface.
    if (WDOG_W == 0) begin : g_wdog_w_unused
    end
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        aybz_d     = aybz_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_q) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                // Empty FIFO is an underrun: wait here, still busy.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_out;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (cur_q.op == OP_RSVD) begin
                    err_d   = 1'b1;
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (other_done) err_d = 1'b1;
                if (match_done) begin
                    state_d = ST_SWAP;
                end else if (wdog_hit) begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_SWAP: begin
                aybz_d  = aybz_q ^ cur_q.swap;
                cnt_d   = cnt_q + 1'b1;
                state_d = cur_q.last ? ST_FINISH : ST_FETCH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ownership covers LAUNCH and WAIT only; SWAP is the NONE drain gap.
    // The reserved op maps to NONE through owner_of().
    always_comb begin
        owner_d = OWN_NONE;
        if (state_d == ST_LAUNCH || state_d == ST_WAIT) owner_d = owner_of(cur_d.op);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            go_q         <= 1'b0;
            aybz_q       <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            owner_q      <= OWN_NONE;
            conv_start_q <= 1'b0;
            pool_start_q <= 1'b0;
            nl_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            // go is registered so a go seen outside IDLE can never leak
            // into the following IDLE cycle.
            go_q         <= go && (state_q == ST_IDLE);
            aybz_q       <= aybz_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            owner_q      <= owner_d;
            conv_start_q <= (state_d == ST_LAUNCH) && (cur_d.op == OP_CONV);
            pool_start_q <= (state_d == ST_LAUNCH) && (cur_d.op == OP_POOL);
            nl_start_q   <= (state_d == ST_LAUNCH) && (cur_d.op == OP_NL);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_FINISH);
        end
    end

    // The current command is data: only meaningful after a FETCH loads it.
    always_ff @(posedge clk) begin
        cur_q <= cur_d;
    end

    assign conv_start = conv_start_q;
    assign pool_start = pool_start_q;
    assign nl_start   = nl_start_q;
    assign owner_sel  = owner_q;
    assign aybz_azby  = aybz_q;
    assign busy       = busy_q;
    assign layer_cnt  = cnt_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
